// File: rtl/pic_host_sequencer_pkg.sv
// pic_host_sequencer_pkg: shared FSM encodings, A0 encodings and ICW1 bit positions.
package pic_host_sequencer_pkg;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WR_SETUP  = 3'd1;
  localparam state_t ST_WR_STROBE = 3'd2;
  localparam state_t ST_WR_HOLD   = 3'd3;
  localparam state_t ST_ACK1      = 3'd4;
  localparam state_t ST_ACK_GAP   = 3'd5;
  localparam state_t ST_ACK2      = 3'd6;
  localparam state_t ST_DONE      = 3'd7;
  localparam logic A0_ICW1 = 1'b0;
  localparam logic A0_DATA = 1'b1;
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_INIT = 4;
endpackage

// File: rtl/pic_strobe_timer.sv
// pic_strobe_timer: 4-bit down counter; o_expire marks the last cycle of the loaded duration.
module pic_strobe_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_val,
  output logic       o_expire
);
  logic [3:0] r_cnt;
  assign o_expire = r_cnt == 4'd0;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= 4'd0;
    else if (i_load) r_cnt <= i_val - 4'd1;
    else if (!o_expire) r_cnt <= r_cnt - 4'd1;
  end
endmodule

// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer: drives 8259-style ICW init writes, OCW writes and INTA vector fetches.
module pic_host_sequencer
  import pic_host_sequencer_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_init_start,
  input  logic [7:0] i_icw1_val,
  input  logic [7:0] i_icw2_val,
  input  logic [7:0] i_icw3_val,
  input  logic [7:0] i_icw4_val,
  input  logic       i_ocw_req,
  input  logic       i_ocw_a0,
  input  logic [7:0] i_ocw_data,
  input  logic       i_int,
  input  logic [7:0] i_data_in,
  output logic [7:0] o_data_out,
  output logic       o_data_oe,
  output logic       o_cs_,
  output logic       o_wr_,
  output logic       o_rd_,
  output logic       o_inta_,
  output logic       o_a0,
  output logic [7:0] o_vector,
  output logic       o_vector_valid,
  output logic       o_ocw_ack,
  output logic       o_ready,
  output logic       o_busy
);
  localparam logic [3:0] W_STB = STROBE_CYCLES[3:0];
  localparam logic [3:0] W_GAP = GAP_CYCLES[3:0];
  state_t     r_state, w_next;
  logic       r_ready, r_ocw_ack, r_is_ocw, r_a0;
  logic [7:0] r_dout, r_vector;
  logic [7:0] r_list [4];
  logic [2:0] r_len;
  logic [1:0] r_idx;
  logic       w_expire, w_init_go, w_more, w_load;
  logic [3:0] w_load_val;
  assign w_init_go = i_init_start && i_icw1_val[ICW1_INIT];
  assign w_more    = !r_is_ocw && ({1'b0, r_idx} + 3'd1 != r_len);
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      w_next = w_init_go ? ST_WR_SETUP :
                             (r_ready && i_int) ? ST_ACK1 :
                             (r_ready && i_ocw_req && !r_ocw_ack) ? ST_WR_SETUP : ST_IDLE;
      ST_WR_SETUP:  w_next = w_expire ? ST_WR_STROBE : r_state;
      ST_WR_STROBE: w_next = w_expire ? ST_WR_HOLD : r_state;
      ST_WR_HOLD:   w_next = w_expire ? (w_more ? ST_WR_SETUP : ST_IDLE) : r_state;
      ST_ACK1:      w_next = w_expire ? ST_ACK_GAP : r_state;
      ST_ACK_GAP:   w_next = w_expire ? ST_ACK2 : r_state;
      ST_ACK2:      w_next = w_expire ? ST_DONE : r_state;
      default:      w_next = ST_IDLE;
    endcase
  end
  assign w_load     = w_next != r_state;
  assign w_load_val = (w_next == ST_WR_STROBE || w_next == ST_ACK1 || w_next == ST_ACK2) ? W_STB :
                      (w_next == ST_WR_HOLD || w_next == ST_ACK_GAP) ? W_GAP : 4'd1;
  pic_strobe_timer u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_val   (w_load_val),
    .o_expire(w_expire)
  );
  // ICW3 slot is filled with ICW4 in single mode so the list stays contiguous.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_IDLE && w_init_go) begin
      r_list[0] <= i_icw1_val;
      r_list[1] <= i_icw2_val;
      r_list[2] <= i_icw1_val[ICW1_SNGL] ? i_icw4_val : i_icw3_val;
      r_list[3] <= i_icw4_val;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b0;
      r_ocw_ack <= 1'b0;
      r_is_ocw  <= 1'b0;
      r_a0      <= 1'b0;
      r_dout    <= 8'h00;
      r_vector  <= 8'h00;
      r_len     <= 3'd0;
      r_idx     <= 2'd0;
    end else begin
      r_state   <= w_next;
      r_ocw_ack <= 1'b0;
      if (r_state == ST_IDLE && w_init_go) begin
        r_ready  <= 1'b0;
        r_is_ocw <= 1'b0;
        r_idx    <= 2'd0;
        r_len    <= 3'd2 + {2'b0, ~i_icw1_val[ICW1_SNGL]} + {2'b0, i_icw1_val[ICW1_IC4]};
        r_dout   <= i_icw1_val;
        r_a0     <= A0_ICW1;
      end else if (r_state == ST_IDLE && w_next == ST_WR_SETUP) begin
        r_is_ocw <= 1'b1;
        r_dout   <= i_ocw_data;
        r_a0     <= i_ocw_a0;
      end
      if (r_state == ST_WR_HOLD && w_expire) begin
        if (w_more) begin
          r_idx  <= r_idx + 2'd1;
          r_dout <= r_list[r_idx + 2'd1];
          r_a0   <= A0_DATA;
        end else if (r_is_ocw) r_ocw_ack <= 1'b1;
        else r_ready <= 1'b1;
      end
      if (r_state == ST_ACK2 && w_expire) r_vector <= i_data_in;
    end
  end
  assign o_data_out     = r_dout;
  assign o_a0           = r_a0;
  assign o_data_oe      = r_state == ST_WR_SETUP || r_state == ST_WR_STROBE || r_state == ST_WR_HOLD;
  assign o_cs_          = !o_data_oe;
  assign o_wr_          = r_state != ST_WR_STROBE;
  assign o_rd_          = 1'b1;
  assign o_inta_        = !(r_state == ST_ACK1 || r_state == ST_ACK2);
  assign o_vector       = r_vector;
  assign o_vector_valid = r_state == ST_DONE;
  assign o_ocw_ack      = r_ocw_ack;
  assign o_ready        = r_ready;
  assign o_busy         = r_state != ST_IDLE;
endmodule

// File: tb/tb_pic_host_sequencer.sv
// tb_pic_host_sequencer: directed checks of init lists, INTA fetch, OCW arbitration and reset.
module tb_pic_host_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic init_start = 1'b0, ocw_req = 1'b0, ocw_a0 = 1'b0, int_r = 1'b0;
  logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00, ocw_data = 8'h00, data_in = 8'h00;
  logic [7:0] data_out, vector;
  logic data_oe, cs_, wr_, rd_, inta_, a0, vector_valid, ocw_ack, ready, busy;
  int n_cmp = 0, n_err = 0;
  int nwr = 0, wlen = 0, ninta = 0, nvv = 0, nack = 0, bad_inta = 0, base;
  logic [7:0] wdata [64];
  logic       wa0 [64];
  int         wwid [64];
  logic prev_wr = 1'b1, prev_inta = 1'b1;
  time t_inta = 0, t_wr = 0;

  pic_host_sequencer #(.STROBE_CYCLES(2), .GAP_CYCLES(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_init_start(init_start),
    .i_icw1_val(icw1), .i_icw2_val(icw2), .i_icw3_val(icw3), .i_icw4_val(icw4),
    .i_ocw_req(ocw_req), .i_ocw_a0(ocw_a0), .i_ocw_data(ocw_data),
    .i_int(int_r), .i_data_in(data_in),
    .o_data_out(data_out), .o_data_oe(data_oe), .o_cs_(cs_), .o_wr_(wr_), .o_rd_(rd_),
    .o_inta_(inta_), .o_a0(a0), .o_vector(vector), .o_vector_valid(vector_valid),
    .o_ocw_ack(ocw_ack), .o_ready(ready), .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!wr_) begin
      if (prev_wr) begin
        wdata[nwr] = data_out;
        wa0[nwr]   = a0;
        wlen       = 0;
        if (t_wr == 0) t_wr = $time;
      end
      wlen++;
    end else if (!prev_wr) begin
      wwid[nwr] = wlen;
      nwr++;
    end
    prev_wr = wr_;
    if (!inta_ && prev_inta) begin
      ninta++;
      if (t_inta == 0) t_inta = $time;
    end
    if (!inta_ && (data_oe || !cs_ || !rd_)) bad_inta++;
    prev_inta = inta_;
    if (vector_valid) nvv++;
    if (ocw_ack) nack++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_init(input logic [7:0] v1, v2, v3, v4);
    @(negedge clk);
    icw1 = v1; icw2 = v2; icw3 = v3; icw4 = v4;
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    check(tag, ready, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cs", cs_, 1'b1);
    check("rst_wr", wr_, 1'b1);
    check("rst_rd", rd_, 1'b1);
    check("rst_inta", inta_, 1'b1);
    check("rst_a0", a0, 1'b0);
    check("rst_dout", data_out, 8'h00);
    check("rst_oe", data_oe, 1'b0);
    check("rst_vec", vector, 8'h00);
    check("rst_flags", {vector_valid, ocw_ack, ready, busy}, 4'b0000);

    int_r = 1'b1;
    repeat (10) @(negedge clk);
    check("int_not_ready_inta", ninta, 0);
    check("int_not_ready_busy", busy, 1'b0);
    int_r = 1'b0;

    start_init(8'h13, 8'h20, 8'hAA, 8'h01);
    wait_ready("init3_ready");
    check("init3_nwr", nwr, 3);
    check("init3_d0", {wa0[0], wdata[0]}, {1'b0, 8'h13});
    check("init3_d1", {wa0[1], wdata[1]}, {1'b1, 8'h20});
    check("init3_d2", {wa0[2], wdata[2]}, {1'b1, 8'h01});
    check("init3_wid", {wwid[0][3:0], wwid[1][3:0], wwid[2][3:0]}, 12'h222);

    start_init(8'h03, 8'h20, 8'hAA, 8'h01);
    check("noinit_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    check("noinit_nwr", nwr, 3);
    check("noinit_ready", ready, 1'b1);

    base = nwr;
    start_init(8'h11, 8'h08, 8'h04, 8'h01);
    check("init4_ready_clr", ready, 1'b0);
    wait_ready("init4_ready");
    check("init4_nwr", nwr - base, 4);
    check("init4_d0", {wa0[base], wdata[base]}, {1'b0, 8'h11});
    check("init4_d1", {wa0[base+1], wdata[base+1]}, {1'b1, 8'h08});
    check("init4_d2", {wa0[base+2], wdata[base+2]}, {1'b1, 8'h04});
    check("init4_d3", {wa0[base+3], wdata[base+3]}, {1'b1, 8'h01});
    for (int k = 0; k < 4; k++) check("init4_wid", wwid[base+k], 2);

    base = ninta;
    int_r = 1'b1; data_in = 8'h25;
    for (int i = 0; i < 50 && !vector_valid; i++) @(negedge clk);
    check("inta_vv", vector_valid, 1'b1);
    check("inta_vec", vector, 8'h25);
    int_r = 1'b0;
    repeat (10) @(negedge clk);
    check("inta_pulses", ninta - base, 2);
    check("inta_vv_count", nvv, 1);
    check("inta_bus_idle", bad_inta, 0);

    @(negedge clk);
    t_inta = 0; t_wr = 0; base = nwr;
    data_in = 8'h31;
    int_r = 1'b1; ocw_req = 1'b1; ocw_a0 = 1'b1; ocw_data = 8'hFE;
    for (int i = 0; i < 50 && !vector_valid; i++) @(negedge clk);
    check("arb_vv", vector_valid, 1'b1);
    check("arb_vec", vector, 8'h31);
    int_r = 1'b0;
    for (int i = 0; i < 50 && !ocw_ack; i++) @(negedge clk);
    check("arb_ack", ocw_ack, 1'b1);
    ocw_req = 1'b0;
    repeat (10) @(negedge clk);
    check("arb_order", (t_inta != 0) && (t_inta < t_wr), 1'b1);
    check("arb_nwr", nwr - base, 1);
    check("arb_ocw", {wa0[base], wdata[base]}, {1'b1, 8'hFE});
    check("arb_ack_count", nack, 1);
    check("arb_ready", ready, 1'b1);

    start_init(8'h13, 8'h20, 8'hAA, 8'h01);
    for (int i = 0; i < 20 && wr_; i++) @(negedge clk);
    check("rst_mid_wr_low", wr_, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_wr", wr_, 1'b1);
    check("rst_mid_cs", cs_, 1'b1);
    check("rst_mid_oe", data_oe, 1'b0);
    check("rst_mid_busy_ready", {busy, ready}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_ready_after", ready, 1'b0);
    check("rst_mid_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
